riscv_iq: RTL

RISCV_IQ -- requirements
Module: riscv_iq

---
 rtl/riscv_iq.sv | 106 ++++++++++
 1 files changed

// File: rtl/riscv_iq.sv
// riscv_iq: instruction queue between the fetch unit and decode.
// Circular FIFO of DEPTH entries carrying address, instruction bits and an
// 8-bit sequence tag, with a registered stall hint and a sticky overflow flag.
module riscv_iq #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STALL_THRESH = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ifu_vld,
    input  logic [31:0]                  ifu_addr,
    input  logic [31:0]                  ifu_data,
    input  logic                         flush,
    output logic                         iq_stall,
    output logic                         iq_vld,
    input  logic                         iq_rdy,
    output logic [31:0]                  iq_addr,
    output logic [31:0]                  iq_data,
    output logic                         iq_rvc,
    output logic [7:0]                   iq_tag,
    output logic [$clog2(DEPTH+1)-1:0]   iq_count,
    output logic                         iq_ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [7:0]    tag_mem  [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    tag_cnt;

    logic          full;
    logic          push;
    logic          pop;

    // Handshake decode; a pop frees a slot so a full queue can still accept.
    always_comb begin
        full = (count == FULL_CNT);
        pop  = (count != '0) && iq_rdy;
        push = ifu_vld && !flush && (!full || pop);
    end

    // Control state: pointers, occupancy, tag counter and sticky overflow.
    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_cnt <= '0;
            iq_ovf  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                tag_cnt <= tag_cnt + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (ifu_vld && full && !pop) begin
                iq_ovf <= 1'b1;
            end
        end
    end

    // Entry storage; no reset needed since occupancy gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= ifu_addr;
            data_mem[wr_ptr] <= ifu_data;
            tag_mem[wr_ptr]  <= tag_cnt;
        end
    end

    // Head outputs from registered state only; a NOP is presented when empty.
    always_comb begin
        iq_count = count;
        iq_vld   = (count != '0);
        iq_stall = (32'(count) >= STALL_THRESH);
        iq_addr  = '0;
        iq_data  = 32'h0000_0013;
        iq_tag   = '0;
        if (iq_vld) begin
            iq_addr = addr_mem[rd_ptr];
            iq_data = data_mem[rd_ptr];
            iq_tag  = tag_mem[rd_ptr];
        end
        iq_rvc = iq_vld && (iq_data[1:0] != 2'b11);
    end

endmodule
